bram_arbiter: RTL and testbench

- N-port to 1-port BRAM arbiter that generalises the 2:1 statically-selected BRAM mux.
- Per-cycle hardware arbitration replaces the external `sel`: round-robin or fixed-priority, with an optional bounded lock for bursts.
- Read-data return is tracked through the BRAM read latency, so each requester gets its own data-valid strobe.
- Sits between several HLS BRAM_CTRL masters and one shared BRAM port.

---
 rtl/bram_arbiter_pkg.sv | 24 ++
 rtl/bram_arbiter_rr_arbiter.sv | 44 ++++
 rtl/bram_arbiter.sv | 137 +++++++++++++
 tb/tb_bram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared constants, types and helpers for the N:1 BRAM arbiter.
package bram_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Widest requester index the read pipeline has to carry (N_PORTS <= 16).
    localparam int IDX_W_MAX = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [IDX_W_MAX-1:0] idx;
    } rd_entry_t;

endpackage

// File: rtl/bram_arbiter_rr_arbiter.sv
// Combinational winner selection: rotating-priority or lowest-index-first,
// restricted to the ports allowed by lock_mask.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               fixed_mode,
    input  logic [N_PORTS-1:0] lock_mask,
    output logic [N_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [N_PORTS-1:0] eligible;
    logic [IDX_W-1:0]   start;

    assign eligible = req & lock_mask;
    assign start    = fixed_mode ? '0 : ptr;

    // Walk every port once from start; the wrap is an explicit compare so
    // non-power-of-two port counts work.
    always_comb begin
        logic [IDX_W-1:0] pos;
        logic             found;
        pos     = start;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!found && eligible[pos]) begin
                found   = 1'b1;
                gnt_idx = pos;
            end
            pos = (pos == IDX_W'(N_PORTS - 1)) ? '0 : pos + 1'b1;
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// N-port to 1-port BRAM arbiter with same-cycle grant, bounded burst lock and
// per-requester read-data return tracked through the BRAM read latency.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WEN_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int N_PORTS    = 4,
    parameter int RD_LATENCY = 1,
    parameter int ARB_MODE   = ARB_RR,
    parameter int MAX_LOCK   = 16
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]   P_Addr,
    input  logic [N_PORTS-1:0]              P_EN,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   P_Din,
    input  logic [N_PORTS*WEN_WIDTH-1:0]    P_WEN,
    input  logic [N_PORTS-1:0]              P_Lock,
    output logic [N_PORTS-1:0]              P_Gnt,
    output logic [N_PORTS*DATA_WIDTH-1:0]   P_Dout,
    output logic [N_PORTS-1:0]              P_Dout_Valid,
    output logic [ADDR_WIDTH-1:0]           O_Addr,
    output logic                            O_EN,
    output logic [DATA_WIDTH-1:0]           O_Din,
    input  logic [DATA_WIDTH-1:0]           O_Dout,
    output logic [WEN_WIDTH-1:0]            O_WEN,
    output logic                            O_Clk,
    output logic                            O_Rst
);

    localparam int IDX_W = clog2(N_PORTS);

    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t        state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   lock_idx_reg;
    logic [7:0]         lock_cnt_reg;
    rd_entry_t          rd_pipe_reg [RD_LATENCY];

    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] lock_mask;
    logic [N_PORTS-1:0] gnt;
    logic [IDX_W-1:0]   g;
    logic [IDX_W-1:0]   ptr_next;
    logic               any_gnt;
    logic               is_read;
    logic               lock_done;
    rd_entry_t          tail;

    // Requests are masked during reset so nothing is granted or queued.
    assign req       = Rst ? '0 : P_EN;
    assign lock_mask = (state_reg == LOCKED)
                     ? ({{(N_PORTS-1){1'b0}}, 1'b1} << lock_idx_reg) : '1;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .ptr        (rr_ptr_reg),
        .fixed_mode (ARB_MODE == ARB_FIXED),
        .lock_mask  (lock_mask),
        .gnt        (gnt),
        .gnt_idx    (g)
    );

    assign any_gnt   = |gnt;
    assign P_Gnt     = gnt;
    assign O_EN      = any_gnt;
    assign O_Addr    = any_gnt ? P_Addr[g*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign O_Din     = any_gnt ? P_Din[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign O_WEN     = any_gnt ? P_WEN[g*WEN_WIDTH +: WEN_WIDTH] : '0;
    assign is_read   = any_gnt && (O_WEN == '0);
    assign ptr_next  = (g == IDX_W'(N_PORTS - 1)) ? '0 : g + 1'b1;
    assign lock_done = ({1'b0, lock_cnt_reg} + 9'd1) >= 9'(MAX_LOCK);
    assign O_Clk     = Clk;
    assign O_Rst     = Rst;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            lock_idx_reg <= '0;
            lock_cnt_reg <= '0;
        end else if (any_gnt) begin
            case (state_reg)
                IDLE: begin
                    // A single-grant lock budget would release immediately.
                    if (P_Lock[g] && MAX_LOCK > 1) begin
                        state_reg    <= LOCKED;
                        lock_idx_reg <= g;
                        lock_cnt_reg <= 8'd1;
                    end else begin
                        rr_ptr_reg <= ptr_next;
                    end
                end
                LOCKED: begin
                    if (!P_Lock[g]) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= ptr_next;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 8'd1;
                        if (lock_done) begin
                            state_reg  <= IDLE;
                            rr_ptr_reg <= ptr_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_pipe_reg[i] <= '0;
            end
        end else begin
            rd_pipe_reg[0] <= '{valid: is_read, idx: IDX_W_MAX'(g)};
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe_reg[i] <= rd_pipe_reg[i-1];
            end
        end
    end

    assign tail = rd_pipe_reg[RD_LATENCY-1];

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_ret
        assign P_Dout_Valid[gi] = !Rst && tail.valid && (tail.idx == IDX_W_MAX'(gi));
        assign P_Dout[gi*DATA_WIDTH +: DATA_WIDTH] = P_Dout_Valid[gi] ? O_Dout : '0;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: a round-robin instance (latency 1, lock limit 3) and a
// fixed-priority instance (latency 2), each in front of a small BRAM model.
module tb_bram_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]   en     [2];
    logic [3:0]   lock   [2];
    logic [31:0]  addr   [2][4];
    logic [31:0]  din    [2][4];
    logic [3:0]   wen    [2][4];

    logic [3:0]   gnt    [2];
    logic [127:0] dout   [2];
    logic [3:0]   dv     [2];
    logic [31:0]  o_addr [2];
    logic         o_en   [2];
    logic [31:0]  o_din  [2];
    logic [31:0]  o_dout [2];
    logic [3:0]   o_wen  [2];
    logic         o_clk  [2];
    logic         o_rst  [2];

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb [$];

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return {8'hA5, a, 8'h5A, ~a};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [127:0] addr_v;
        logic [127:0] din_v;
        logic [15:0]  wen_v;
        logic [31:0]  mem [256];
        logic [255:0] wr_flag;
        logic [31:0]  rd_q [2];

        for (genvar gj = 0; gj < 4; gj++) begin : g_port
            assign addr_v[gj*32 +: 32] = addr[gi][gj];
            assign din_v[gj*32 +: 32]  = din[gi][gj];
            assign wen_v[gj*4 +: 4]    = wen[gi][gj];
        end

        // Unwritten locations read back a fixed address-derived pattern.
        always @(posedge clk) begin
            if (rst) begin
                wr_flag <= '0;
            end else if (o_en[gi] && o_wen[gi] != 4'h0) begin
                mem[o_addr[gi][7:0]]     <= o_din[gi];
                wr_flag[o_addr[gi][7:0]] <= 1'b1;
            end
            if (o_en[gi] && o_wen[gi] == 4'h0) begin
                rd_q[0] <= wr_flag[o_addr[gi][7:0]] ? mem[o_addr[gi][7:0]]
                                                    : init_word(o_addr[gi][7:0]);
            end
            rd_q[1] <= rd_q[0];
        end
        assign o_dout[gi] = rd_q[gi];

        bram_arbiter #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .N_PORTS    (4),
            .RD_LATENCY (gi + 1),
            .ARB_MODE   (gi),
            .MAX_LOCK   ((gi == 0) ? 3 : 16)
        ) u_dut (
            .Clk          (clk),
            .Rst          (rst),
            .P_Addr       (addr_v),
            .P_EN         (en[gi]),
            .P_Din        (din_v),
            .P_WEN        (wen_v),
            .P_Lock       (lock[gi]),
            .P_Gnt        (gnt[gi]),
            .P_Dout       (dout[gi]),
            .P_Dout_Valid (dv[gi]),
            .O_Addr       (o_addr[gi]),
            .O_EN         (o_en[gi]),
            .O_Din        (o_din[gi]),
            .O_Dout       (o_dout[gi]),
            .O_WEN        (o_wen[gi]),
            .O_Clk        (o_clk[gi]),
            .O_Rst        (o_rst[gi])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            en[d]   = 4'h0;
            lock[d] = 4'h0;
            for (int p = 0; p < 4; p++) wen[d][p] = 4'h0;
        end
    endtask

    task automatic expect_rd(input int d, input int p, input logic [31:0] data);
        sb.push_back('{d, p, data, cyc + d + 1});
    endtask

    // Scoreboard: each read-data strobe must match the oldest expected entry
    // exactly on its due cycle; any other strobe is spurious.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (sb.size() != 0 && sb[0].inst == d && sb[0].due == cyc) begin
                check("rd_valid", 128'(dv[d]), 128'(1) << sb[0].port);
                check("rd_dout", dout[d], 128'(sb[0].data) << (32 * sb[0].port));
                $display("rd inst%0d port%0d data %h cycle %0d", d, sb[0].port, dout[d][32*sb[0].port +: 32], cyc);
                void'(sb.pop_front());
            end else if (dv[d] != 4'h0) begin
                check("spurious_valid", 128'(dv[d]), 128'(0));
            end
        end
    end

    logic [3:0] t3_en   [8] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0100, 4'b1011};
    logic [3:0] t3_lock [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    int         t3_port [8] = '{2, 2, 2, 0, 2, -1, 2, 3};

    initial begin
        rst = 1'b1;
        idle_all();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                addr[d][p] = 32'h0;
                din[d][p]  = 32'h0;
            end
        end

        // Requests during reset are never granted.
        tick();
        en[0] = 4'hF;
        @(negedge clk);
        check("rst_gnt", gnt[0], 0);
        check("rst_oen", o_en[0], 0);
        tick();
        idle_all();
        rst = 1'b0;

        // Round-robin rotation with all four ports reading.
        for (int k = 0; k < 8; k++) begin
            tick();
            en[0] = 4'hF;
            for (int p = 0; p < 4; p++) addr[0][p] = 32'h40 + p;
            expect_rd(0, k % 4, init_word(8'h40 + 8'(k % 4)));
            @(negedge clk);
            check("rr_gnt", gnt[0], 128'(1) << (k % 4));
            check("rr_oaddr", o_addr[0], 32'h40 + k % 4);
        end
        tick();
        idle_all();
        @(negedge clk);
        check("idle_oen", o_en[0], 0);
        check("idle_oaddr", o_addr[0], 0);
        tick();

        // Lock: three grants to port 2, forced release, pointer lands on 3.
        for (int k = 0; k < 8; k++) begin
            tick();
            en[0]   = t3_en[k];
            lock[0] = t3_lock[k];
            for (int p = 0; p < 4; p++) addr[0][p] = 32'h60 + p;
            if (t3_port[k] >= 0) expect_rd(0, t3_port[k], init_word(8'h60 + 8'(t3_port[k])));
            @(negedge clk);
            check("lock_gnt", gnt[0], (t3_port[k] >= 0) ? (128'(1) << t3_port[k]) : 128'(0));
            check("lock_oen", o_en[0], (t3_port[k] >= 0) ? 128'(1) : 128'(0));
        end

        // Write from port 1, then read it back.
        tick();
        idle_all();
        en[0]      = 4'b0010;
        addr[0][1] = 32'h8;
        din[0][1]  = 32'hDEADBEEF;
        wen[0][1]  = 4'hF;
        @(negedge clk);
        check("wr_gnt", gnt[0], 4'b0010);
        check("wr_owen", o_wen[0], 4'hF);
        check("wr_odin", o_din[0], 32'hDEADBEEF);
        check("wr_oaddr", o_addr[0], 32'h8);
        tick();
        idle_all();
        @(negedge clk);
        check("idle_odin", o_din[0], 0);
        check("idle_owen", o_wen[0], 0);
        tick();
        en[0] = 4'b0010;
        expect_rd(0, 1, 32'hDEADBEEF);
        @(negedge clk);
        check("rdback_gnt", gnt[0], 4'b0010);
        tick();
        idle_all();
        repeat (2) tick();

        // Fixed priority: port 1 beats port 3 every cycle.
        for (int k = 0; k < 3; k++) begin
            tick();
            en[1]      = 4'b1010;
            addr[1][1] = 32'h11;
            addr[1][3] = 32'h13;
            expect_rd(1, 1, init_word(8'h11));
            @(negedge clk);
            check("fix_gnt", gnt[1], 4'b0010);
            check("fix_oaddr", o_addr[1], 32'h11);
        end
        tick();
        idle_all();
        repeat (3) tick();

        // Latency 2: back-to-back reads from ports 0 and 3 return in order.
        tick();
        en[1]      = 4'b0001;
        addr[1][0] = 32'h10;
        expect_rd(1, 0, init_word(8'h10));
        @(negedge clk);
        check("lat_gnt0", gnt[1], 4'b0001);
        tick();
        en[1]      = 4'b1000;
        addr[1][3] = 32'h20;
        expect_rd(1, 3, init_word(8'h20));
        @(negedge clk);
        check("lat_gnt3", gnt[1], 4'b1000);
        tick();
        idle_all();
        repeat (3) tick();

        // Reset with a read in flight; round-robin side is left locked on port 2.
        tick();
        en[1]      = 4'b0001;
        addr[1][0] = 32'h30;
        en[0]      = 4'b0100;
        lock[0]    = 4'b0100;
        addr[0][2] = 32'h70;
        din[0][2]  = 32'h12345678;
        wen[0][2]  = 4'hF;
        @(negedge clk);
        check("pre_rst_gnt1", gnt[1], 4'b0001);
        check("pre_rst_gnt0", gnt[0], 4'b0100);
        tick();
        idle_all();
        rst   = 1'b1;
        en[1] = 4'b0001;
        @(negedge clk);
        check("in_rst_gnt", gnt[1], 0);
        check("in_rst_oen", o_en[1], 0);
        check("in_rst_dv", dv[1], 0);
        tick();
        rst = 1'b0;
        idle_all();
        en[0]      = 4'b1001;
        addr[0][0] = 32'h80;
        addr[0][3] = 32'h83;
        expect_rd(0, 0, init_word(8'h80));
        @(negedge clk);
        check("post_rst_gnt", gnt[0], 4'b0001);
        tick();
        idle_all();
        repeat (4) tick();

        @(negedge clk);
        check("sb_drain", 128'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
